// File: rtl/bitfusion_psum_acc.sv
// Partial-sum accumulator: sums a programmable-length group of psum beats, then holds the result on a valid/ready port.
// Optional saturating arithmetic is enabled with `define BITFUSION_PSUM_ACC_SAT_EN.
module bitfusion_psum_acc #(
    parameter int PSUM_W = 16,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [LEN_W-1:0]  acc_len,
    input  logic              psum_signed,
    input  logic              psum_valid,
    output logic              psum_ready,
    input  logic [PSUM_W-1:0] psum,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              sat_flag
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W:0]     cnt_q, cnt_d;
    logic [LEN_W:0]     grp_len_q, grp_len_d;
    logic               grp_signed_q, grp_signed_d;
    logic               sat_q, sat_d;

    logic               beat;
    logic               sign_sel;
    logic [ACC_W-1:0]   ext;
    logic [LEN_W:0]     eff_len;
    logic [LEN_W:0]     cnt_inc;
    logic [ACC_W-1:0]   add_res;
    logic               add_clamp;

    assign psum_ready = (state_q != DONE);
    assign out_valid  = (state_q == DONE);
    assign acc_out    = acc_q;
    assign sat_flag   = sat_q;

    assign beat     = psum_valid && psum_ready;
    assign sign_sel = (state_q == IDLE) ? psum_signed : grp_signed_q;
    // acc_len of zero maps to 2^LEN_W: the MSB is set exactly when the low bits are zero
    assign eff_len  = {(acc_len == '0), acc_len};
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        if (sign_sel) begin
            ext = ACC_W'($signed(psum));
        end else begin
            ext = ACC_W'(psum);
        end
    end

`ifdef BITFUSION_PSUM_ACC_SAT_EN
    logic [ACC_W:0] sum_w;

    always_comb begin
        if (grp_signed_q) begin
            sum_w     = {acc_q[ACC_W-1], acc_q} + {ext[ACC_W-1], ext};
            add_clamp = sum_w[ACC_W] ^ sum_w[ACC_W-1];
            if (!add_clamp) begin
                add_res = sum_w[ACC_W-1:0];
            end else if (sum_w[ACC_W]) begin
                add_res = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                add_res = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            sum_w     = {1'b0, acc_q} + {1'b0, ext};
            add_clamp = sum_w[ACC_W];
            add_res   = add_clamp ? '1 : sum_w[ACC_W-1:0];
        end
    end
`else
    always_comb begin
        add_res   = acc_q + ext;
        add_clamp = 1'b0;
    end
`endif

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        grp_len_d    = grp_len_q;
        grp_signed_d = grp_signed_q;
        sat_d        = sat_q;

        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beat) begin
                        acc_d        = ext;
                        grp_len_d    = eff_len;
                        grp_signed_d = psum_signed;
                        cnt_d        = (LEN_W+1)'(1);
                        sat_d        = 1'b0;
                        state_d      = (eff_len == (LEN_W+1)'(1)) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_d = add_res;
                        sat_d = sat_q | add_clamp;
                        cnt_d = cnt_inc;
                        if (cnt_inc == grp_len_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        sat_d   = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            grp_len_q    <= '0;
            grp_signed_q <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            grp_len_q    <= grp_len_d;
            grp_signed_q <= grp_signed_d;
            sat_q        <= sat_d;
        end
    end

endmodule

// File: tb/tb_bitfusion_psum_acc.sv
// Directed bench for bitfusion_psum_acc: expected group sums go into a queue when a group is driven
// and are popped when the DUT completes the output handshake.
module tb_bitfusion_psum_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [7:0]  acc_len;
    logic        psum_signed;
    logic        psum_valid;
    logic [15:0] psum;
    logic        out_ready;

    logic        psum_ready, out_valid, sat_flag;
    logic [31:0] acc_out;
    logic        psum_ready16, out_valid16, sat16;
    logic [15:0] acc_out16;

`ifdef BITFUSION_PSUM_ACC_SAT_EN
    localparam logic [15:0] OVF_ACC = 16'hFFFF;
    localparam logic        OVF_SAT = 1'b1;
`else
    localparam logic [15:0] OVF_ACC = 16'h0001;
    localparam logic        OVF_SAT = 1'b0;
`endif

    bitfusion_psum_acc #(.PSUM_W(16), .ACC_W(32), .LEN_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .acc_len(acc_len), .psum_signed(psum_signed),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum(psum),
        .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .sat_flag(sat_flag)
    );

    // Narrow instance shares all inputs so it tracks the same groups; used for the overflow case
    bitfusion_psum_acc #(.PSUM_W(16), .ACC_W(16), .LEN_W(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .acc_len(acc_len), .psum_signed(psum_signed),
        .psum_valid(psum_valid), .psum_ready(psum_ready16), .psum(psum),
        .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc_out16), .sat_flag(sat16)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic send(input logic [15:0] d, output int waits);
        logic got;
        got   = 1'b0;
        waits = 0;
        psum_valid = 1'b1;
        psum       = d;
        while (!got && waits < 50) begin
            @(negedge clk);
            if (psum_ready) got = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        psum_valid = 1'b0;
        check("send_accept", 32'(got), 32'd1);
    endtask

    task automatic collect(input int hold);
        logic [31:0] expv;
        int n;
        n = 0;
        while (!out_valid && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("out_valid_seen", 32'(out_valid), 32'd1);
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_acc_out", acc_out, expv);
            check("hold_psum_ready", 32'(psum_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("acc_out", acc_out, expv);
        check("sat_flag", 32'(sat_flag), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("ready_back", 32'(psum_ready), 32'd1);
        $display("txn: group sum %h observed %h", expv, acc_out);
    endtask

    initial begin
        int w;
        int gap;
        rst_n       = 1'b0;
        clr         = 1'b0;
        psum_valid  = 1'b0;
        psum        = '0;
        acc_len     = '0;
        psum_signed = 1'b0;
        out_ready   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_acc_out", acc_out, 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        check("rst_psum_ready", 32'(psum_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unsigned, back-to-back
        acc_len = 8'd4; psum_signed = 1'b0;
        exp_q.push_back(32'h0000_FF11);
        send(16'h0010, w); send(16'h00FF, w); send(16'hFE01, w); send(16'h0001, w);
        check("t1_latency", 32'(out_valid), 32'd1);
        check("t1_ready_low", 32'(psum_ready), 32'd0);
        collect(0);

        // Signed with backpressure; mid-group control changes must be ignored
        acc_len = 8'd3; psum_signed = 1'b1;
        exp_q.push_back(32'hFFFF_FFF4);
        send(16'hFFF0, w);
        acc_len = 8'd1; psum_signed = 1'b0;
        send(16'h0005, w); send(16'hFFFF, w);
        collect(5);

        // Length 1, beat accepted in the cycle right after the handshake
        acc_len = 8'd1; psum_signed = 1'b0;
        exp_q.push_back(32'h0000_7FFF);
        send(16'h7FFF, w);
        check("t3_no_wait", 32'(w), 32'd0);
        check("t3_latency", 32'(out_valid), 32'd1);
        collect(0);

        // acc_len=0 means 256 beats, with random gaps
        acc_len = 8'd0;
        exp_q.push_back(32'd256);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) check("t4_not_early", 32'(out_valid), 32'd0);
            send(16'h0001, w);
            if (i < 255) begin
                gap = $urandom_range(0, 2);
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        check("t4_latency", 32'(out_valid), 32'd1);
        collect(1);

        // Abort: clr drops a concurrent beat and returns to IDLE
        acc_len = 8'd4;
        send(16'h0003, w); send(16'h0003, w);
        psum_valid = 1'b1; psum = 16'h0003; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; psum_valid = 1'b0;
        check("t5_clr_valid", 32'(out_valid), 32'd0);
        check("t5_clr_acc", acc_out, 32'd0);
        check("t5_clr_ready", 32'(psum_ready), 32'd1);
        acc_len = 8'd1;
        exp_q.push_back(32'd2);
        send(16'h0002, w);
        check("t5_latency", 32'(out_valid), 32'd1);
        collect(0);

        // Asynchronous reset while holding a result
        acc_len = 8'd1;
        send(16'h1234, w);
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_acc", acc_out, 32'h0000_1234);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(out_valid), 32'd0);
        check("t6_async_acc", acc_out, 32'd0);
        check("t6_async_valid16", 32'(out_valid16), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t6_ready_after", 32'(psum_ready), 32'd1);
        check("t6_valid_after", 32'(out_valid), 32'd0);

        // Overflow on the 16-bit instance; 32-bit instance holds the exact sum
        acc_len = 8'd2; psum_signed = 1'b0;
        exp_q.push_back(32'h0001_0001);
        send(16'hFFFF, w); send(16'h0002, w);
        check("t7_valid16", 32'(out_valid16), 32'd1);
        check("t7_acc16", 32'(acc_out16), 32'(OVF_ACC));
        check("t7_sat16", 32'(sat16), 32'(OVF_SAT));
        $display("txn: 16-bit overflow sum observed %h sat %0d", acc_out16, sat16);
        collect(0);
        check("t7_sat16_clear", 32'(sat16), 32'd0);
        check("t7_valid16_drop", 32'(out_valid16), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
